// File: rtl/subckt_walk_pkg.sv
// rtl/subckt_walk_pkg.sv - shared types and constants for the subcircuit hierarchy walker
//
// Purpose: index width of stack frames, the NULL link value, event/error
// encodings, the walker FSM state type and the stack frame layout.
package subckt_walk_pkg;

  localparam int FRAME_IDX_W = 8;

  // All-ones index marks "no child" / "no sibling" in the instance table.
  localparam logic [FRAME_IDX_W-1:0] NULL_IDX = '1;

  typedef enum logic [0:0] {
    EV_ENTER = 1'b0,
    EV_LEAVE = 1'b1
  } ev_kind_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_DEPTH = 2'd1,
    ERR_LOOP  = 2'd2
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ENTER,
    S_DESCEND,
    S_LEAVE,
    S_NEXT,
    S_FINISH
  } state_e;

  // A parent frame: where to emit LEAVE and where to continue afterwards.
  typedef struct packed {
    logic [FRAME_IDX_W-1:0] idx;
    logic [FRAME_IDX_W-1:0] sibling;
  } frame_t;

endpackage

// File: rtl/subckt_walk_ctrl_stack.sv
// rtl/subckt_walk_ctrl_stack.sv - synchronous LIFO of parent frames for the hierarchy walker
//
// Purpose: holds up to MAX_DEPTH frames; top shows the most recent push.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         discard all frames
//   push, pop     one operation per cycle; both at once is illegal
//   push_frame    frame written on push
//   top           most recently pushed frame (undefined when count is 0)
//   count         number of frames held
module walk_stack
  import subckt_walk_pkg::*;
#(
  parameter int MAX_DEPTH = 8,
  parameter int CNT_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  frame_t           push_frame,
  output frame_t           top,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(MAX_DEPTH);

  frame_t           mem [MAX_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign wr_ptr = PTR_W'(count);
  assign rd_ptr = PTR_W'(count - CNT_W'(1));
  assign top    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (push) begin
      count <= count + CNT_W'(1);
    end else if (pop) begin
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && pop));
    end
  end

endmodule

// File: rtl/subckt_walk_ctrl.sv
// rtl/subckt_walk_ctrl.sv - depth-first walker over a flattened subcircuit instance table
//
// Purpose: reads child/sibling links from an external synchronous RAM and
// emits ENTER/LEAVE events for every instance below root_idx.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, root_idx          begin a walk (accepted only when idle)
//   busy, done, err          status; done/err are one-cycle pulses
//   err_code                 0 none, 1 depth overflow, 2 loop guard; held
//   mem_rd_en, mem_addr      table read request
//   mem_child, mem_sibling   table read data, one cycle after mem_rd_en
//   ev_valid, ev_ready       event handshake
//   ev_leave, ev_idx, ev_depth  event payload
module subckt_walk_ctrl
  import subckt_walk_pkg::*;
#(
  parameter int IDX_W     = FRAME_IDX_W,
  parameter int MAX_DEPTH = 8,
  parameter int DEPTH_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   root_idx,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code,
  output logic               mem_rd_en,
  output logic [IDX_W-1:0]   mem_addr,
  input  logic [IDX_W-1:0]   mem_child,
  input  logic [IDX_W-1:0]   mem_sibling,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic               ev_leave,
  output logic [IDX_W-1:0]   ev_idx,
  output logic [DEPTH_W-1:0] ev_depth
);

  localparam int               CNT_W       = $clog2(MAX_DEPTH + 1);
  localparam logic [IDX_W-1:0] FETCH_LIMIT = '1;
  localparam logic [CNT_W-1:0] DEPTH_LAST  = CNT_W'(MAX_DEPTH - 1);

  state_e           state, state_n;
  logic [IDX_W-1:0] cur, child_q, sib, fetch_cnt;
  err_code_e        err_code_q;
  logic             err_q;
  logic             accept, do_push, do_pop, take_sib;
  logic             abort_depth, abort_loop, loop_hit, stack_clear;
  frame_t           push_frame, top_frame;
  logic [CNT_W-1:0] depth;

  // The stack occupancy is the current depth: one frame per open ancestor.
  walk_stack #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .clear      (stack_clear),
    .push       (do_push),
    .pop        (do_pop),
    .push_frame (push_frame),
    .top        (top_frame),
    .count      (depth)
  );

  assign loop_hit    = (fetch_cnt == FETCH_LIMIT);
  assign stack_clear = accept || abort_depth || abort_loop;
  assign push_frame  = '{idx: cur, sibling: sib};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    take_sib    = 1'b0;
    abort_depth = 1'b0;
    abort_loop  = 1'b0;
    case (state)
      // err_q high means the abort pulse is out this cycle; start waits a cycle.
      S_IDLE: if (start && !err_q) begin
        accept  = 1'b1;
        state_n = S_FETCH;
      end
      S_FETCH: if (loop_hit) begin
        abort_loop = 1'b1;
        state_n    = S_IDLE;
      end else begin
        state_n = S_WAIT;
      end
      S_WAIT: state_n = S_ENTER;
      S_ENTER: if (ev_ready) begin
        if (child_q == NULL_IDX) begin
          state_n = S_LEAVE;
        end else if (depth == DEPTH_LAST) begin
          abort_depth = 1'b1;
          state_n     = S_IDLE;
        end else begin
          state_n = S_DESCEND;
        end
      end
      S_DESCEND: begin
        do_push = 1'b1;
        state_n = S_FETCH;
      end
      S_LEAVE: if (ev_ready) state_n = S_NEXT;
      S_NEXT: if (depth == '0) begin
        state_n = S_FINISH;
      end else if (sib != NULL_IDX) begin
        take_sib = 1'b1;
        state_n  = S_FETCH;
      end else begin
        // Parent's own sibling comes back from the stack; no fetch needed.
        do_pop  = 1'b1;
        state_n = S_LEAVE;
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      child_q    <= '0;
      sib        <= '0;
      fetch_cnt  <= '0;
      err_code_q <= ERR_NONE;
      err_q      <= 1'b0;
    end else begin
      err_q <= abort_depth || abort_loop;
      if (accept) begin
        cur        <= root_idx;
        fetch_cnt  <= '0;
        err_code_q <= ERR_NONE;
      end
      if (abort_depth) err_code_q <= ERR_DEPTH;
      if (abort_loop)  err_code_q <= ERR_LOOP;
      if (state == S_FETCH && !loop_hit) fetch_cnt <= fetch_cnt + IDX_W'(1);
      if (state == S_WAIT) begin
        child_q <= mem_child;
        sib     <= mem_sibling;
      end
      if (do_push)  cur <= child_q;
      if (take_sib) cur <= sib;
      if (do_pop) begin
        cur <= top_frame.idx;
        sib <= top_frame.sibling;
      end
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_FINISH);
  assign done      = (state == S_FINISH);
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign mem_rd_en = (state == S_FETCH) && !loop_hit;
  assign mem_addr  = cur;
  assign ev_valid  = (state == S_ENTER) || (state == S_LEAVE);
  assign ev_leave  = (state == S_LEAVE) ? EV_LEAVE : EV_ENTER;
  assign ev_idx    = cur;
  assign ev_depth  = DEPTH_W'(depth);

endmodule

// File: tb/tb_subckt_walk_ctrl.sv
// tb/tb_subckt_walk_ctrl.sv - directed bench for subckt_walk_ctrl
module tb_subckt_walk_ctrl;

  localparam logic [7:0] NUL = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] root_idx;
  logic       ev_ready;
  logic       start [3];
  logic       busy [3], done [3], err [3], mem_rd_en [3], ev_valid [3], ev_leave [3];
  logic [1:0] err_code [3];
  logic [7:0] mem_addr [3], mem_child [3], mem_sibling [3], ev_idx [3];
  logic [3:0] ev_depth0, ev_depth1;
  logic [7:0] ev_depth2;
  logic [7:0] tbl_child [256];
  logic [7:0] tbl_sib [256];

  int tests = 0;
  int fails = 0;
  int evq [$];
  int exp1 [10];
  int fetches, stab_viol, overlap;
  bit got_done, got_err, end_busy, end_valid;

  subckt_walk_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start[0]), .root_idx(root_idx),
    .busy(busy[0]), .done(done[0]), .err(err[0]), .err_code(err_code[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]),
    .mem_child(mem_child[0]), .mem_sibling(mem_sibling[0]),
    .ev_valid(ev_valid[0]), .ev_ready(ev_ready), .ev_leave(ev_leave[0]),
    .ev_idx(ev_idx[0]), .ev_depth(ev_depth0)
  );

  subckt_walk_ctrl #(.MAX_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start[1]), .root_idx(root_idx),
    .busy(busy[1]), .done(done[1]), .err(err[1]), .err_code(err_code[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]),
    .mem_child(mem_child[1]), .mem_sibling(mem_sibling[1]),
    .ev_valid(ev_valid[1]), .ev_ready(ev_ready), .ev_leave(ev_leave[1]),
    .ev_idx(ev_idx[1]), .ev_depth(ev_depth1)
  );

  subckt_walk_ctrl #(.MAX_DEPTH(256), .DEPTH_W(8)) u_deep (
    .clk(clk), .rst(rst), .start(start[2]), .root_idx(root_idx),
    .busy(busy[2]), .done(done[2]), .err(err[2]), .err_code(err_code[2]),
    .mem_rd_en(mem_rd_en[2]), .mem_addr(mem_addr[2]),
    .mem_child(mem_child[2]), .mem_sibling(mem_sibling[2]),
    .ev_valid(ev_valid[2]), .ev_ready(ev_ready), .ev_leave(ev_leave[2]),
    .ev_idx(ev_idx[2]), .ev_depth(ev_depth2)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mem_rd_en[k]) begin
        mem_child[k]   <= tbl_child[mem_addr[k]];
        mem_sibling[k] <= tbl_sib[mem_addr[k]];
      end
    end
  end

  function automatic int w(input int lv, input int idx, input int dep);
    return (lv << 16) | (idx << 8) | dep;
  endfunction

  function automatic int ev_word(input int s);
    int d;
    d = (s == 0) ? int'(ev_depth0) : (s == 1) ? int'(ev_depth1) : int'(ev_depth2);
    return w(int'(ev_leave[s]), int'(ev_idx[s]), d);
  endfunction

  task automatic clear_table;
    for (int k = 0; k < 256; k++) begin
      tbl_child[k] = NUL;
      tbl_sib[k]   = NUL;
    end
  endtask

  task automatic load_table1;
    clear_table();
    tbl_child[0] = 8'd1;
    tbl_sib[1]   = 8'd2;
    tbl_child[2] = 8'd3;
    tbl_sib[2]   = 8'd4;
    exp1 = '{w(0,0,0), w(0,1,1), w(1,1,1), w(0,2,1), w(0,3,2),
             w(1,3,2), w(1,2,1), w(0,4,1), w(1,4,1), w(1,0,0)};
  endtask

  // Runs one walk on instance s, recording transferred events until done/err.
  task automatic collect(input int s, input logic [7:0] r, input int max_cyc,
                         input bit rnd, input int poke, input logic [7:0] poke_root);
    int  prev;
    bit  hold;
    evq.delete();
    fetches = 0; stab_viol = 0; overlap = 0;
    got_done = 0; got_err = 0; end_busy = 0; end_valid = 0;
    hold = 0; prev = 0;
    @(posedge clk); #1;
    start[s] = 1'b1;
    root_idx = r;
    ev_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (mem_rd_en[s]) fetches++;
      if (mem_rd_en[s] && ev_valid[s]) overlap++;
      if (hold && (!ev_valid[s] || ev_word(s) != prev)) stab_viol++;
      hold = ev_valid[s] && !ev_ready;
      prev = ev_word(s);
      if (ev_valid[s] && ev_ready) evq.push_back(ev_word(s));
      if (done[s] || err[s]) begin
        got_done  = done[s];
        got_err   = err[s];
        end_busy  = busy[s];
        end_valid = ev_valid[s];
        break;
      end
      @(posedge clk); #1;
      start[s] = (c + 1 == poke);
      if (c + 1 == poke) root_idx = poke_root;
      ev_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
    @(posedge clk); #1;
    start[s] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (busy[s] !== 1'b0 || done[s] !== 1'b0 || err[s] !== 1'b0) begin
        fails++;
        $display("FAIL reset_status[%0d] busy=%b done=%b err=%b required 0/0/0", s, busy[s], done[s], err[s]);
      end
      tests++;
      if (ev_valid[s] !== 1'b0 || mem_rd_en[s] !== 1'b0 || err_code[s] !== 2'd0) begin
        fails++;
        $display("FAIL reset_outputs[%0d] ev_valid=%b mem_rd_en=%b err_code=%0d required 0", s, ev_valid[s], mem_rd_en[s], err_code[s]);
      end
      tests++;
      if (mem_addr[s] !== 8'd0 || ev_idx[s] !== 8'd0 || ev_leave[s] !== 1'b0) begin
        fails++;
        $display("FAIL reset_fields[%0d] mem_addr=%0d ev_idx=%0d ev_leave=%b required 0", s, mem_addr[s], ev_idx[s], ev_leave[s]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_walk_basic;
    load_table1();
    collect(0, 8'd0, 300, 1'b0, -1, 8'd0);
    tests++;
    if (evq.size() != 10) begin
      fails++;
      $display("FAIL basic_count got %0d events required 10", evq.size());
    end
    for (int i = 0; i < 10 && i < evq.size(); i++) begin
      tests++;
      if (evq[i] !== exp1[i]) begin
        fails++;
        $display("FAIL basic_event[%0d] got %06h required %06h", i, evq[i], exp1[i]);
      end
    end
    tests++;
    if (!got_done || got_err || end_busy || err_code[0] !== 2'd0) begin
      fails++;
      $display("FAIL basic_end done=%b err=%b busy=%b err_code=%0d required 1/0/0/0", got_done, got_err, end_busy, err_code[0]);
    end
    tests++;
    if (done[0] !== 1'b0) begin
      fails++;
      $display("FAIL basic_done_pulse done=%b one cycle later required 0", done[0]);
    end
    tests++;
    if (overlap != 0) begin
      fails++;
      $display("FAIL basic_overlap got %0d cycles with ev_valid and mem_rd_en required 0", overlap);
    end
  endtask

  task automatic test_random_ready;
    load_table1();
    collect(0, 8'd0, 600, 1'b1, -1, 8'd0);
    tests++;
    if (evq.size() != 10) begin
      fails++;
      $display("FAIL rnd_count got %0d events required 10", evq.size());
    end
    for (int i = 0; i < 10 && i < evq.size(); i++) begin
      tests++;
      if (evq[i] !== exp1[i]) begin
        fails++;
        $display("FAIL rnd_event[%0d] got %06h required %06h", i, evq[i], exp1[i]);
      end
    end
    tests++;
    if (stab_viol != 0 || !got_done) begin
      fails++;
      $display("FAIL rnd_stable violations=%0d done=%b required 0 and 1", stab_viol, got_done);
    end
  endtask

  task automatic test_depth_overflow;
    clear_table();
    for (int k = 0; k < 4; k++) tbl_child[k] = 8'(k + 1);
    collect(1, 8'd0, 300, 1'b0, -1, 8'd0);
    tests++;
    if (evq.size() != 4) begin
      fails++;
      $display("FAIL depth_count got %0d events required 4", evq.size());
    end
    for (int i = 0; i < 4 && i < evq.size(); i++) begin
      tests++;
      if (evq[i] !== w(0, i, i)) begin
        fails++;
        $display("FAIL depth_event[%0d] got %06h required %06h", i, evq[i], w(0, i, i));
      end
    end
    tests++;
    if (!got_err || got_done || end_busy || end_valid || err_code[1] !== 2'd1) begin
      fails++;
      $display("FAIL depth_abort err=%b done=%b busy=%b ev_valid=%b err_code=%0d required 1/0/0/0/1", got_err, got_done, end_busy, end_valid, err_code[1]);
    end
    tests++;
    if (err[1] !== 1'b0 || err_code[1] !== 2'd1) begin
      fails++;
      $display("FAIL depth_hold err=%b err_code=%0d required 0 and 1", err[1], err_code[1]);
    end
  endtask

  task automatic test_loop_guard;
    clear_table();
    tbl_child[0] = 8'd0;
    collect(2, 8'd0, 3000, 1'b0, -1, 8'd0);
    tests++;
    if (fetches != 255) begin
      fails++;
      $display("FAIL loop_fetches got %0d required 255", fetches);
    end
    tests++;
    if (evq.size() != 255 || (evq.size() > 0 && evq[evq.size()-1] !== w(0, 0, 254))) begin
      fails++;
      $display("FAIL loop_events got %0d events required 255 ending at depth 254", evq.size());
    end
    tests++;
    if (!got_err || end_busy || end_valid || err_code[2] !== 2'd2) begin
      fails++;
      $display("FAIL loop_abort err=%b busy=%b ev_valid=%b err_code=%0d required 1/0/0/2", got_err, end_busy, end_valid, err_code[2]);
    end
  endtask

  task automatic test_root_leaf;
    int busy_seen;
    clear_table();
    tbl_sib[5] = 8'd3;
    collect(0, 8'd5, 100, 1'b0, 2, 8'd2);
    tests++;
    if (evq.size() != 2 || evq[0] !== w(0, 5, 0) || evq[1] !== w(1, 5, 0)) begin
      fails++;
      $display("FAIL leaf_events got %0d events first %06h required 2 events E5/0 L5/0", evq.size(), (evq.size() > 0) ? evq[0] : -1);
    end
    tests++;
    if (!got_done || err_code[0] !== 2'd0) begin
      fails++;
      $display("FAIL leaf_done done=%b err_code=%0d required 1 and 0", got_done, err_code[0]);
    end
    collect(0, 8'd5, 100, 1'b0, 6, 8'd2);
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy[0]) busy_seen++;
    end
    tests++;
    if (busy_seen != 0 || !got_done) begin
      fails++;
      $display("FAIL start_on_done busy cycles=%0d done=%b required 0 and 1", busy_seen, got_done);
    end
  endtask

  task automatic test_reset_mid_walk;
    bit found;
    int pulses;
    found = 0;
    load_table1();
    @(posedge clk); #1;
    start[0] = 1'b1;
    root_idx = 8'd0;
    ev_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (ev_valid[0] && ev_depth0 == 4'd2) begin
        found = 1;
        ev_ready = 1'b0;
        break;
      end
      @(posedge clk); #1;
      start[0] = 1'b0;
    end
    start[0] = 1'b0;
    tests++;
    if (!found || ev_idx[0] !== 8'd3 || ev_leave[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_reach found=%b idx=%0d leave=%b required 1/3/0", found, ev_idx[0], ev_leave[0]);
    end
    @(posedge clk); #1;
    tests++;
    if (ev_valid[0] !== 1'b1 || ev_idx[0] !== 8'd3 || ev_depth0 !== 4'd2) begin
      fails++;
      $display("FAIL midrst_hold ev_valid=%b idx=%0d depth=%0d required 1/3/2", ev_valid[0], ev_idx[0], ev_depth0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (busy[0] !== 1'b0 || ev_valid[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0) begin
      fails++;
      $display("FAIL midrst_state busy=%b ev_valid=%b done=%b err=%b required 0", busy[0], ev_valid[0], done[0], err[0]);
    end
    rst = 1'b0;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (done[0] || err[0] || busy[0]) pulses++;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL midrst_quiet got %0d active cycles required 0", pulses);
    end
    collect(0, 8'd0, 300, 1'b0, -1, 8'd0);
    tests++;
    if (evq.size() != 10 || !got_done) begin
      fails++;
      $display("FAIL midrst_rerun got %0d events done=%b required 10 and 1", evq.size(), got_done);
    end
    for (int i = 0; i < 10 && i < evq.size(); i++) begin
      tests++;
      if (evq[i] !== exp1[i]) begin
        fails++;
        $display("FAIL midrst_event[%0d] got %06h required %06h", i, evq[i], exp1[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    root_idx = 8'd0;
    ev_ready = 1'b0;
    for (int s = 0; s < 3; s++) start[s] = 1'b0;
    clear_table();
    test_reset();
    test_walk_basic();
    test_random_ready();
    test_depth_overflow();
    test_loop_guard();
    test_root_leaf();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
